if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Holds the PC and drives a single-cycle request/ack port to instruction memory; that memory is shared with the MEM stage, so ack can be withheld.
- Presents {addr, instr, valid} to decode; accepts branch redirect (one delay slot), stall and interrupt flush from decode/scheduler.

---
 rtl/if_stage.sv | 194 +++++++++++++++++++
 tb/tb_if_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage: instruction fetch stage with IF/ID pipeline register.
//
// Holds the PC and drives a single-cycle request/ack port to instruction
// memory. Instruction memory is shared with the MEM stage, so the ack may be
// withheld. The stage presents {addr, instr, valid} to decode. It supports a
// branch redirect with one delay slot, a stall/hold, and an interrupt flush.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   ifi_stall         hold IF/ID contents
//   ifi_branch        redirect request from decode, target on ifi_new_pc
//   ifi_int           interrupt/ERET flush; highest priority
//   ifo_mem_req       fetch request (registered, from state only)
//   ifo_mem_addr      fetch address (= pc)
//   ifi_mem_ack       fetch data valid; only counts while ifo_mem_req=1
//   ifi_mem_data      fetched instruction
//   ifo_addr          IF/ID instruction address
//   ifo_instr         IF/ID instruction
//   ifo_valid         IF/ID holds a real instruction
//   ifo_fetch_count   accepted-fetch counter
//
// Build option: IF_PERF_CNT_EN enables the saturating fetch counter.
// Without it, ifo_fetch_count is tied to zero.
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] INT_VECTOR = 16'h0008,
    parameter logic [15:0] NOP_INSTR  = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifi_stall,
    input  logic        ifi_branch,
    input  logic [15:0] ifi_new_pc,
    input  logic        ifi_int,
    output logic        ifo_mem_req,
    output logic [15:0] ifo_mem_addr,
    input  logic        ifi_mem_ack,
    input  logic [15:0] ifi_mem_data,
    output logic [15:0] ifo_addr,
    output logic [15:0] ifo_instr,
    output logic        ifo_valid,
    output logic [15:0] ifo_fetch_count
);

    localparam int unsigned W = 16;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic           req_q, req_d;
    logic           redir_q, redir_d;
    logic [W-1:0]   redir_pc_q, redir_pc_d;
    logic [W-1:0]   hold_addr_q, hold_addr_d;
    logic [W-1:0]   hold_instr_q, hold_instr_d;
    logic [W-1:0]   addr_q, addr_d;
    logic [W-1:0]   instr_q, instr_d;
    logic           valid_q, valid_d;

    logic           ack_c;
    logic [W-1:0]   next_pc_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            redir_q      <= 1'b0;
            redir_pc_q   <= '0;
            hold_addr_q  <= '0;
            hold_instr_q <= '0;
            addr_q       <= '0;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            redir_q      <= redir_d;
            redir_pc_q   <= redir_pc_d;
            hold_addr_q  <= hold_addr_d;
            hold_instr_q <= hold_instr_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
        end
    end

    // Next-state logic: fetch/hold sequencing, redirect, and flush
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_d      = redir_q;
        redir_pc_d   = redir_pc_q;
        hold_addr_d  = hold_addr_q;
        hold_instr_d = hold_instr_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        valid_d      = valid_q;

        // An ack only counts against an outstanding request
        ack_c     = ifi_mem_ack & req_q & (state_q == FETCH);
        next_pc_c = redir_q ? redir_pc_q : pc_q + W'(1);

        if (ifi_int) begin
            // Flush: discard any ack and any pending redirect, restart at the vector
            state_d      = FETCH;
            pc_d         = INT_VECTOR;
            redir_d      = 1'b0;
            hold_addr_d  = '0;
            hold_instr_d = '0;
            instr_d      = NOP_INSTR;
            valid_d      = 1'b0;
        end else if (state_q == FETCH) begin
            if (ack_c) begin
                redir_d = 1'b0;
                if (!ifi_stall) begin
                    addr_d  = pc_q;
                    instr_d = ifi_mem_data;
                    valid_d = 1'b1;
                    // A branch arriving with the ack makes this fetch the delay slot
                    pc_d    = ifi_branch ? ifi_new_pc : next_pc_c;
                end else begin
                    hold_addr_d  = pc_q;
                    hold_instr_d = ifi_mem_data;
                    pc_d         = next_pc_c;
                    state_d      = HOLD;
                end
            end else if (!ifi_stall) begin
                addr_d  = pc_q;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                // Delay slot not fetched yet: remember target until the ack lands
                if (ifi_branch) begin
                    redir_d    = 1'b1;
                    redir_pc_d = ifi_new_pc;
                end
            end
        end else begin
            if (!ifi_stall) begin
                addr_d  = hold_addr_q;
                instr_d = hold_instr_q;
                valid_d = 1'b1;
                state_d = FETCH;
                // Delay slot is the buffered instruction, so redirect pc directly
                if (ifi_branch) begin
                    pc_d = ifi_new_pc;
                end
            end
        end

        req_d = (state_d == FETCH);
    end

    assign ifo_mem_req  = req_q;
    assign ifo_mem_addr = pc_q;
    assign ifo_addr     = addr_q;
    assign ifo_instr    = instr_q;
    assign ifo_valid    = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [W-1:0] cnt_q, cnt_d;
    logic         capture_c;

    // Count acks actually captured into IF/ID or the hold buffer
    assign capture_c = ack_c & ~ifi_int;

    always_comb begin
        cnt_d = cnt_q;
        if (capture_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ifo_fetch_count = cnt_q;
`else
    assign ifo_fetch_count = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage: self-checking bench for if_stage.
// Directed scenarios use expected values taken from the fetch rules. A
// randomized phase compares every cycle against a behavioural model that
// tracks the pc, a parked instruction and a pending branch target with
// queues.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [15:0] NOP  = 16'h0800;
    localparam logic [15:0] IVEC = 16'h0008;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] new_pc = 16'h0;
    logic        intr = 1'b0;
    logic        ack = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] ifo_addr;
    logic [15:0] ifo_instr;
    logic        ifo_valid;
    logic [15:0] fcount;

    int total = 0;
    int bad   = 0;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ifi_stall      (stall),
        .ifi_branch     (branch),
        .ifi_new_pc     (new_pc),
        .ifi_int        (intr),
        .ifo_mem_req    (mem_req),
        .ifo_mem_addr   (mem_addr),
        .ifi_mem_ack    (ack),
        .ifi_mem_data   (mem_data),
        .ifo_addr       (ifo_addr),
        .ifo_instr      (ifo_instr),
        .ifo_valid      (ifo_valid),
        .ifo_fetch_count(fcount)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a function of address
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a * 16'd37) ^ 16'h5A3C;
    endfunction

    assign mem_data = mem_f(mem_addr);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; branch = 1'b0; new_pc = 16'h0; intr = 1'b0; ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // After n ticks with ack=1 (n>=2): IF/ID addr = n-2, pc = n-1, count = n-1
    task automatic run_from_reset(input int n);
        apply_reset();
        ack = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        run_from_reset(5);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
        total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", mem_addr); end
        total++; if (ifo_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", ifo_addr); end
        total++; if (ifo_instr !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", ifo_instr, NOP); end
        total++; if (ifo_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ifo_valid); end
        total++; if (fcount !== 16'h0000) begin bad++; $display("FAIL reset_count: got %h want 0000", fcount); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        apply_reset();
        ack = 1'b1;
        tick();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL seq_req: got %b want 1", mem_req); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem_addr !== 16'(k)) begin bad++; $display("FAIL seq_maddr%0d: got %h want %h", k, mem_addr, 16'(k)); end
            if (k >= 1) begin
                total++;
                if ({ifo_addr, ifo_instr, ifo_valid} !== {16'(k - 1), mem_f(16'(k - 1)), 1'b1}) begin
                    bad++;
                    $display("FAIL seq_ifid%0d: got addr=%h instr=%h v=%b want addr=%h instr=%h v=1",
                             k, ifo_addr, ifo_instr, ifo_valid, 16'(k - 1), mem_f(16'(k - 1)));
                end
            end
            tick();
        end
    endtask

    task automatic test_branch();
        run_from_reset(18);
        total++; if (ifo_addr !== 16'h0010) begin bad++; $display("FAIL br_setup: got %h want 0010", ifo_addr); end
        branch = 1'b1; new_pc = 16'h0040;
        tick();
        branch = 1'b0;
        total++;
        if ({ifo_addr, ifo_instr, ifo_valid} !== {16'h0011, mem_f(16'h0011), 1'b1}) begin
            bad++; $display("FAIL br_slot: got addr=%h instr=%h v=%b want 0011", ifo_addr, ifo_instr, ifo_valid);
        end
        tick();
        total++; if ({ifo_addr, ifo_valid} !== {16'h0040, 1'b1}) begin bad++; $display("FAIL br_tgt: got %h/%b want 0040/1", ifo_addr, ifo_valid); end
        tick();
        total++; if ({ifo_addr, ifo_valid} !== {16'h0041, 1'b1}) begin bad++; $display("FAIL br_tgt1: got %h/%b want 0041/1", ifo_addr, ifo_valid); end
    endtask

    task automatic test_branch_noack();
        run_from_reset(18);
        ack = 1'b0; branch = 1'b1; new_pc = 16'h0040;
        tick();
        branch = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({ifo_instr, ifo_valid} !== {NOP, 1'b0}) begin
                bad++; $display("FAIL brna_bubble%0d: got instr=%h v=%b want 0800/0", k, ifo_instr, ifo_valid);
            end
            if (k == 0) tick();
        end
        ack = 1'b1;
        tick();
        total++;
        if ({ifo_addr, ifo_instr, ifo_valid} !== {16'h0011, mem_f(16'h0011), 1'b1}) begin
            bad++; $display("FAIL brna_slot: got addr=%h instr=%h v=%b want 0011", ifo_addr, ifo_instr, ifo_valid);
        end
        tick();
        total++; if ({ifo_addr, ifo_valid} !== {16'h0040, 1'b1}) begin bad++; $display("FAIL brna_tgt: got %h/%b want 0040/1", ifo_addr, ifo_valid); end
    endtask

    task automatic test_stall();
        run_from_reset(6);
        total++; if (mem_addr !== 16'h0005) begin bad++; $display("FAIL st_setup: got %h want 0005", mem_addr); end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({mem_req, ifo_addr, ifo_valid} !== {1'b0, 16'h0004, 1'b1}) begin
                bad++; $display("FAIL st_frozen%0d: got req=%b addr=%h v=%b want 0/0004/1", k, mem_req, ifo_addr, ifo_valid);
            end
        end
        stall = 1'b0;
        tick();
        total++;
        if ({ifo_addr, ifo_instr, ifo_valid, mem_req, mem_addr} !== {16'h0005, mem_f(16'h0005), 1'b1, 1'b1, 16'h0006}) begin
            bad++; $display("FAIL st_release: got addr=%h instr=%h v=%b req=%b maddr=%h want 0005/%h/1/1/0006",
                            ifo_addr, ifo_instr, ifo_valid, mem_req, mem_addr, mem_f(16'h0005));
        end
        tick();
        total++; if ({ifo_addr, ifo_valid} !== {16'h0006, 1'b1}) begin bad++; $display("FAIL st_resume: got %h/%b want 0006/1", ifo_addr, ifo_valid); end
    endtask

    task automatic test_interrupt();
        run_from_reset(4);
        intr = 1'b1; branch = 1'b1; new_pc = 16'h0040;
        tick();
        intr = 1'b0; branch = 1'b0;
        total++;
        if ({mem_addr, ifo_addr, ifo_instr, ifo_valid} !== {IVEC, 16'h0002, NOP, 1'b0}) begin
            bad++; $display("FAIL int_flush: got maddr=%h addr=%h instr=%h v=%b want 0008/0002/0800/0",
                            mem_addr, ifo_addr, ifo_instr, ifo_valid);
        end
        total++; if (fcount !== (PERF ? 16'd3 : 16'd0)) begin bad++; $display("FAIL int_count: got %0d want %0d", fcount, PERF ? 3 : 0); end
        tick();
        total++; if ({ifo_addr, ifo_valid} !== {IVEC, 1'b1}) begin bad++; $display("FAIL int_vec: got %h/%b want 0008/1", ifo_addr, ifo_valid); end
        total++; if (fcount !== (PERF ? 16'd4 : 16'd0)) begin bad++; $display("FAIL int_count2: got %0d want %0d", fcount, PERF ? 4 : 0); end
        tick();
        total++; if ({ifo_addr, mem_addr} !== {16'h0009, 16'h000A}) begin bad++; $display("FAIL int_next: got %h/%h want 0009/000a", ifo_addr, mem_addr); end
    endtask

    task automatic test_wrap();
        run_from_reset(3);
        branch = 1'b1; new_pc = 16'hFFFF;
        tick();
        branch = 1'b0;
        total++; if (mem_addr !== 16'hFFFF) begin bad++; $display("FAIL wrap_setup: got %h want ffff", mem_addr); end
        tick();
        total++;
        if ({mem_addr, ifo_addr, ifo_valid} !== {16'h0000, 16'hFFFF, 1'b1}) begin
            bad++; $display("FAIL wrap: got maddr=%h addr=%h v=%b want 0000/ffff/1", mem_addr, ifo_addr, ifo_valid);
        end
        tick();
        total++; if (ifo_addr !== 16'h0000) begin bad++; $display("FAIL wrap_next: got %h want 0000", ifo_addr); end
    endtask

    // Random traffic against a model built on a parked-instruction queue and
    // a pending-target queue
    task automatic test_random(input int cycles);
        logic [15:0] m_pc, m_addr, m_instr, m_cnt, succ;
        logic        m_valid, m_req;
        logic [31:0] parked[$];
        logic [15:0] target[$];
        apply_reset();
        m_pc = 16'h0000; m_addr = 16'h0000; m_instr = NOP; m_valid = 1'b0; m_req = 1'b0; m_cnt = 16'h0;
        for (int c = 0; c < cycles; c++) begin
            total++;
            if ({mem_req, mem_addr, ifo_addr, ifo_instr, ifo_valid, fcount} !==
                {m_req, m_pc, m_addr, m_instr, m_valid, (PERF ? m_cnt : 16'h0)}) begin
                bad++;
                $display("FAIL random_c%0d: got req=%b maddr=%h addr=%h instr=%h v=%b cnt=%h want req=%b maddr=%h addr=%h instr=%h v=%b cnt=%h",
                         c, mem_req, mem_addr, ifo_addr, ifo_instr, ifo_valid, fcount,
                         m_req, m_pc, m_addr, m_instr, m_valid, (PERF ? m_cnt : 16'h0));
            end
            stall  = ($urandom_range(0, 3) == 0);
            ack    = ($urandom_range(0, 9) < 7);
            branch = ($urandom_range(0, 6) == 0);
            new_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            intr   = ($urandom_range(0, 24) == 0);
            if (intr) begin
                m_pc = IVEC; m_instr = NOP; m_valid = 1'b0; m_req = 1'b1;
                parked.delete(); target.delete();
            end else if (parked.size() != 0) begin
                if (!stall) begin
                    {m_addr, m_instr} = parked.pop_front();
                    m_valid = 1'b1;
                    m_req   = 1'b1;
                    if (branch) m_pc = new_pc;
                end
            end else begin
                succ = (target.size() != 0) ? target[0] : m_pc + 16'd1;
                if (ack && m_req) begin
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    if (!stall) begin
                        m_addr = m_pc; m_instr = mem_f(m_pc); m_valid = 1'b1;
                        m_pc = branch ? new_pc : succ;
                    end else begin
                        parked.push_back({m_pc, mem_f(m_pc)});
                        m_pc  = succ;
                        m_req = 1'b0;
                    end
                    target.delete();
                end else begin
                    if (!stall) begin
                        m_addr = m_pc; m_instr = NOP; m_valid = 1'b0;
                        if (branch) begin
                            target.delete();
                            target.push_back(new_pc);
                        end
                    end
                    m_req = 1'b1;
                end
            end
            tick();
        end
        stall = 1'b0; ack = 1'b0; branch = 1'b0; intr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_branch_noack();
        test_stall();
        test_interrupt();
        test_wrap();
        test_random(800);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
